inv_data_registers_unit: RTL and testbench
==========================================

INV_DATA_REGISTERS_UNIT -- requirements
Module: inv_data_registers_unit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports named clk and rst_n.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 rst_n  in  1  asynchronous active-low reset.
REQ-004 en  in  1  shift-in/shift-out strobe, two bytes per cycle.
REQ-005 doISR  in  1  single-cycle InvShiftRows command.
REQ-006 doIMC  in  1  starts a 4-cycle InvMixColumns pass.
REQ-007 statein  in  16  incoming bytes; [15:8] is the earlier byte.
REQ-008 stateout  out  16  {s0,s1}, the two oldest state bytes.
REQ-009 imc_busy  out  1  high while an InvMixColumns pass is in progress.
REQ-010 imc_done  out  1  one-cycle pulse in the final InvMixColumns cycle.
REQ-011 block_rdy  out  1  one-cycle pulse on every 8th accepted en cycle.

Function
REQ-012 State SHALL be sixteen bytes s0..s15 in column-major order: byte (row r, column c) = s[r+4c].
REQ-013 Shift (en=1, idle): s[i] <= s[i+2] for i=0..13; s14 <= statein[15:8]; s15 <= statein[7:0].
REQ-014 A 3-bit shift counter SHALL increment on each accepted en and wrap 7->0; block_rdy SHALL pulse in the cycle the counter wraps.
REQ-015 InvShiftRows (doISR=1, idle, en=0): new s[r+4c] = old s[r+4((c-r) mod 4)], completing in one cycle. Row 0 is unchanged.
REQ-016 InvMixColumns SHALL start on doIMC=1 when idle and en=0 and doISR=0. It SHALL run exactly 4 cycles with imc_busy high and a 2-bit column counter counting 0..3.
REQ-017 Each IMC cycle: s0..s11 <= s4..s15; s12..s15 <= InvMixColumn(s0..s3) using coefficient matrix rows {0e,0b,0d,09} rotated, GF(2^8) modulo 0x11B. After 4 cycles the state SHALL be in original column order.
REQ-018 imc_done SHALL pulse in the cycle the column counter equals 3. imc_busy SHALL be low in the following cycle.
REQ-019 Command priority when idle SHALL be en > doISR > doIMC. Lower-priority simultaneous commands are dropped, not queued.
REQ-020 While imc_busy is high, en, doISR and doIMC SHALL be ignored, and the shift counter SHALL hold.
REQ-021 With no command, all state SHALL hold.
REQ-022 stateout SHALL be combinational from s0,s1 and valid in every cycle, with no transform applied.
REQ-023 InvMixColumn SHALL be purely combinational within the cycle; the whole pass has a latency of 4 cycles.

Reset
REQ-024 Asserting rst_n=0 SHALL immediately clear s0..s15, the shift counter and the column counter to 0, and drive imc_busy, imc_done and block_rdy low.
REQ-025 Reset mid-IMC SHALL abort the pass. No imc_done SHALL be produced for the aborted pass.
REQ-026 After reset is released, the first accepted en SHALL be counted as shift 1 of a new block.

Structure
REQ-027 A shared package SHALL hold the reduction constant 8'h1B, the IMC coefficients 0e/0b/0d/09, the state byte count 16 and the IMC pass length 4.
REQ-028 One sub-module, inv_mix_column, SHALL be used: 32-bit column in, 32-bit column out, combinational, built from xtime chains.
REQ-029 Control SHALL be a 2-state FSM (IDLE, IMC) plus the two counters.

Verification
REQ-030 Load bytes 00..0f over 8 en cycles -> block_rdy pulses on cycle 8; stateout = 0001 after the load.
REQ-031 Load 00..0f, then doISR -> s0..s15 = 00 0d 0a 07 04 01 0e 0b 08 05 02 0f 0c 09 06 03.
REQ-032 Load a state whose column 0 is 8e 4d a1 bc and whose other columns are 01 01 01 01, then doIMC -> imc_done 4 cycles later; column 0 = db 13 53 45; other columns unchanged at 01 01 01 01.
REQ-033 Assert en, doISR and doIMC in the same cycle -> only the shift occurs and imc_busy stays low; assert en during imc_busy -> ignored and the shift counter is unchanged.
REQ-034 Assert rst_n=0 in IMC cycle 2 -> all state is 0, imc_busy is low and no imc_done is produced.
REQ-035 Shift the block out over 8 en cycles after ISR and IMC -> stateout streams the bytes in column-major order, and the counter wraps again.

Source files
------------

// File: rtl/inv_data_registers_unit_pkg.sv
// Shared constants, control-state type and GF(2^8) helpers for the
// inverse-cipher state register unit.
package inv_data_registers_unit_pkg;

    localparam logic [7:0] GF_REDUCE = 8'h1B;
    localparam logic [7:0] IMC_C0    = 8'h0E;
    localparam logic [7:0] IMC_C1    = 8'h0B;
    localparam logic [7:0] IMC_C2    = 8'h0D;
    localparam logic [7:0] IMC_C3    = 8'h09;
    localparam int         NUM_BYTES = 16;
    localparam int         IMC_LEN   = 4;

    typedef enum logic {
        IDLE = 1'b0,
        IMC  = 1'b1
    } ctrl_state_t;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? GF_REDUCE : 8'h00);
    endfunction

    // All inverse coefficients fit in four bits, so x1/x2/x4/x8 terms suffice.
    function automatic logic [7:0] gf_mul_coef(input logic [7:0] b, input logic [3:0] c);
        logic [7:0] x2;
        logic [7:0] x4;
        logic [7:0] x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return (c[0] ? b  : 8'h00) ^ (c[1] ? x2 : 8'h00) ^
               (c[2] ? x4 : 8'h00) ^ (c[3] ? x8 : 8'h00);
    endfunction

endpackage

// File: rtl/inv_data_registers_unit_mix.sv
// Combinational InvMixColumn of one 32-bit column; byte 0 (row 0) sits in [31:24].
module inv_mix_column
    import inv_data_registers_unit_pkg::*;
(
    input  logic [31:0] col_in,
    output logic [31:0] col_out
);

    logic [7:0] b0_s;
    logic [7:0] b1_s;
    logic [7:0] b2_s;
    logic [7:0] b3_s;

    // Circulant matrix product, each row the previous one rotated right by one.
    always_comb begin
        b0_s = col_in[31:24];
        b1_s = col_in[23:16];
        b2_s = col_in[15:8];
        b3_s = col_in[7:0];
        col_out[31:24] = gf_mul_coef(b0_s, IMC_C0[3:0]) ^ gf_mul_coef(b1_s, IMC_C1[3:0]) ^
                         gf_mul_coef(b2_s, IMC_C2[3:0]) ^ gf_mul_coef(b3_s, IMC_C3[3:0]);
        col_out[23:16] = gf_mul_coef(b0_s, IMC_C3[3:0]) ^ gf_mul_coef(b1_s, IMC_C0[3:0]) ^
                         gf_mul_coef(b2_s, IMC_C1[3:0]) ^ gf_mul_coef(b3_s, IMC_C2[3:0]);
        col_out[15:8]  = gf_mul_coef(b0_s, IMC_C2[3:0]) ^ gf_mul_coef(b1_s, IMC_C3[3:0]) ^
                         gf_mul_coef(b2_s, IMC_C0[3:0]) ^ gf_mul_coef(b3_s, IMC_C1[3:0]);
        col_out[7:0]   = gf_mul_coef(b0_s, IMC_C1[3:0]) ^ gf_mul_coef(b1_s, IMC_C2[3:0]) ^
                         gf_mul_coef(b2_s, IMC_C3[3:0]) ^ gf_mul_coef(b3_s, IMC_C0[3:0]);
    end

endmodule

// File: rtl/inv_data_registers_unit.sv
// Sixteen-byte inverse-cipher state register: two-byte shift in/out,
// single-cycle InvShiftRows and a four-cycle column-serial InvMixColumns.
module inv_data_registers_unit
    import inv_data_registers_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        doISR,
    input  logic        doIMC,
    input  logic [15:0] statein,
    output logic [15:0] stateout,
    output logic        imc_busy,
    output logic        imc_done,
    output logic        block_rdy
);

    localparam logic [1:0] LAST_COL = 2'(IMC_LEN - 1);

    ctrl_state_t state_r;
    ctrl_state_t state_nxt_s;
    logic [2:0]  shift_cnt_r;
    logic [1:0]  col_cnt_r;
    logic [7:0]  s_r     [NUM_BYTES];
    logic [7:0]  s_nxt_s [NUM_BYTES];
    logic        accept_en_s;
    logic        do_isr_s;
    logic        start_imc_s;
    logic [31:0] imc_col_in_s;
    logic [31:0] imc_col_out_s;

    assign imc_col_in_s = {s_r[0], s_r[1], s_r[2], s_r[3]};

    inv_mix_column u_inv_mix_column (
        .col_in  (imc_col_in_s),
        .col_out (imc_col_out_s)
    );

    // Command arbitration while idle: en beats doISR beats doIMC.
    always_comb begin
        accept_en_s = (state_r == IDLE) && en;
        do_isr_s    = (state_r == IDLE) && !en && doISR;
        start_imc_s = (state_r == IDLE) && !en && !doISR && doIMC;
    end

    // Control state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (start_imc_s) state_nxt_s = IMC;
                else             state_nxt_s = IDLE;
            end
            IMC: begin
                if (col_cnt_r == LAST_COL) state_nxt_s = IDLE;
                else                       state_nxt_s = IMC;
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Shift counter holds outside accepted shifts; column counter idles at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_cnt_r <= 3'd0;
            col_cnt_r   <= 2'd0;
        end else begin
            if (accept_en_s) shift_cnt_r <= shift_cnt_r + 3'd1;
            else             shift_cnt_r <= shift_cnt_r;
            if (state_r == IMC) col_cnt_r <= col_cnt_r + 2'd1;
            else                col_cnt_r <= 2'd0;
        end
    end

    // Next state bytes; the IMC rotation returns columns to their original slots after four steps.
    always_comb begin
        for (int i = 0; i < NUM_BYTES; i++) s_nxt_s[i] = s_r[i];
        if (accept_en_s) begin
            for (int i = 0; i < NUM_BYTES - 2; i++) s_nxt_s[i] = s_r[i + 2];
            s_nxt_s[14] = statein[15:8];
            s_nxt_s[15] = statein[7:0];
        end else if (do_isr_s) begin
            for (int r = 0; r < 4; r++) begin
                for (int c = 0; c < 4; c++) begin
                    s_nxt_s[r + 4 * c] = s_r[r + 4 * ((c - r) & 3)];
                end
            end
        end else if (state_r == IMC) begin
            for (int i = 0; i < NUM_BYTES - 4; i++) s_nxt_s[i] = s_r[i + 4];
            s_nxt_s[12] = imc_col_out_s[31:24];
            s_nxt_s[13] = imc_col_out_s[23:16];
            s_nxt_s[14] = imc_col_out_s[15:8];
            s_nxt_s[15] = imc_col_out_s[7:0];
        end else begin
            for (int i = 0; i < NUM_BYTES; i++) s_nxt_s[i] = s_r[i];
        end
    end

    // State byte registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_BYTES; i++) s_r[i] <= 8'h00;
        end else begin
            for (int i = 0; i < NUM_BYTES; i++) s_r[i] <= s_nxt_s[i];
        end
    end

    // Outputs decoded from registered state.
    always_comb begin
        stateout  = {s_r[0], s_r[1]};
        imc_busy  = (state_r == IMC);
        imc_done  = (state_r == IMC) && (col_cnt_r == LAST_COL);
        block_rdy = accept_en_s && (shift_cnt_r == 3'd7);
    end

endmodule

// File: tb/tb_inv_data_registers_unit.sv
// Scoreboard bench: a byte-array reference model predicts every cycle's outputs,
// a negedge monitor pops and compares them against the DUT.
module tb_inv_data_registers_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        doISR = 1'b0;
    logic        doIMC = 1'b0;
    logic [15:0] statein = 16'h0000;
    logic [15:0] stateout;
    logic        imc_busy;
    logic        imc_done;
    logic        block_rdy;

    always #5 clk = ~clk;

    inv_data_registers_unit dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .doISR     (doISR),
        .doIMC     (doIMC),
        .statein   (statein),
        .stateout  (stateout),
        .imc_busy  (imc_busy),
        .imc_done  (imc_done),
        .block_rdy (block_rdy)
    );

    typedef struct {
        logic [15:0] so;
        logic        busy;
        logic        done;
        logic        rdy;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_x;
    int   total = 0;
    int   bad = 0;

    // Reference model: state as a plain byte array, block counter, pass progress.
    logic [7:0] m [16];
    int         m_cnt = 0;
    int         m_k = 0;
    bit         m_busy = 1'b0;

    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] p;
        a = a_in;
        b = b_in;
        p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
            b = {1'b0, b[7:1]};
        end
        return p;
    endfunction

    task automatic model_invmix();
        logic [7:0] coef [4];
        logic [7:0] t [16];
        logic [7:0] acc;
        coef = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                acc = 8'h00;
                for (int k = 0; k < 4; k++) acc = acc ^ gmul(coef[(k - r + 4) % 4], m[k + 4 * c]);
                t[r + 4 * c] = acc;
            end
        end
        for (int j = 0; j < 16; j++) m[j] = t[j];
    endtask

    task automatic model_isr();
        logic [7:0] t [16];
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                t[r + 4 * c] = m[r + 4 * ((c - r + 4) % 4)];
        for (int j = 0; j < 16; j++) m[j] = t[j];
    endtask

    // One clock cycle: drive inputs, predict outputs, advance the model past the edge.
    task automatic step(input logic e, input logic i, input logic c, input logic [15:0] d, input logic r);
        exp_t x;
        en = e;
        doISR = i;
        doIMC = c;
        statein = d;
        rst_n = !r;
        if (r) begin
            for (int j = 0; j < 16; j++) m[j] = 8'h00;
            m_cnt = 0;
            m_busy = 1'b0;
            m_k = 0;
        end
        x.so   = m_busy ? {m[4 * m_k], m[4 * m_k + 1]} : {m[0], m[1]};
        x.busy = m_busy;
        x.done = m_busy && (m_k == 3);
        x.rdy  = !r && !m_busy && e && (m_cnt == 7);
        exp_q.push_back(x);
        @(posedge clk);
        #1;
        if (r) begin
            m_cnt = 0;
        end else if (m_busy) begin
            m_k = m_k + 1;
            if (m_k == 4) begin
                model_invmix();
                m_busy = 1'b0;
                m_k = 0;
            end
        end else if (e) begin
            for (int j = 0; j < 14; j++) m[j] = m[j + 2];
            m[14] = d[15:8];
            m[15] = d[7:0];
            m_cnt = (m_cnt + 1) % 8;
        end else if (i) begin
            model_isr();
        end else if (c) begin
            m_busy = 1'b1;
            m_k = 0;
        end
    endtask

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: every predicted cycle is compared at the falling edge.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_x = exp_q.pop_front();
            chk("stateout", stateout, mon_x.so);
            chk("imc_busy", {15'd0, imc_busy}, {15'd0, mon_x.busy});
            chk("imc_done", {15'd0, imc_done}, {15'd0, mon_x.done});
            chk("block_rdy", {15'd0, block_rdy}, {15'd0, mon_x.rdy});
        end
    end

    logic [15:0] imc_load [8];

    initial begin
        for (int j = 0; j < 16; j++) m[j] = 8'h00;
        imc_load = '{16'h8e4d, 16'ha1bc, 16'h0101, 16'h0101,
                     16'h0101, 16'h0101, 16'h0101, 16'h0101};
        @(posedge clk);
        #1;
        repeat (3) step(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1);
        step(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);

        // Load bytes 00..0f, then ISR.
        for (int j = 0; j < 8; j++) step(1'b1, 1'b0, 1'b0, {8'(2 * j), 8'(2 * j + 1)}, 1'b0);
        step(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
        step(1'b0, 1'b1, 1'b0, 16'h0000, 1'b0);

        // Stream the ISR result out while loading the IMC column vector.
        for (int j = 0; j < 8; j++) step(1'b1, 1'b0, 1'b0, imc_load[j], 1'b0);
        step(1'b0, 1'b0, 1'b1, 16'h0000, 1'b0);
        // Commands during the pass must be ignored.
        repeat (4) step(1'b1, 1'b1, 1'b1, 16'($urandom), 1'b0);
        step(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
        for (int j = 0; j < 8; j++) step(1'b1, 1'b0, 1'b0, 16'($urandom), 1'b0);

        // All three commands together: shift only.
        step(1'b1, 1'b1, 1'b1, 16'hbeef, 1'b0);
        step(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);

        // Randomised command mix.
        for (int n = 0; n < 400; n++) begin
            step(1'($urandom_range(0, 9) < 4), 1'($urandom_range(0, 9) < 2),
                 1'($urandom_range(0, 9) < 2), 16'($urandom), 1'b0);
        end

        // Reset in the second cycle of a pass, then a fresh block.
        while (m_busy) step(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
        step(1'b0, 1'b0, 1'b1, 16'h0000, 1'b0);
        step(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
        repeat (2) step(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1);
        repeat (5) step(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
        for (int j = 0; j < 9; j++) step(1'b1, 1'b0, 1'b0, 16'($urandom), 1'b0);
        repeat (2) step(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);

        for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(negedge clk);
        if (exp_q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain actual=%0d required=0 pending entries", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
